quad_updown_decoder: RTL and testbench



---
 rtl/quad_updown_decoder_pkg.sv | 37 +++
 rtl/quad_updown_decoder_sync_ff.sv | 24 ++
 rtl/quad_updown_decoder.sv | 123 ++++++++++++
 tb/tb_quad_updown_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/quad_updown_decoder_pkg.sv
// Shared constants, FSM encoding and transition helpers for the quadrature decoder.
package quad_pkg;

    // AB phase states, written as {a, b}
    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    typedef enum logic {
        ARMING = 1'b0,
        TRACK  = 1'b1
    } fsm_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when prev -> cur is one step of the up sequence 00->01->11->10->00
    function automatic logic is_up_step(input logic [1:0] prev, input logic [1:0] cur);
        logic up;
        up = 1'b0;
        case (prev)
            ST_00: up = (cur == ST_01);
            ST_01: up = (cur == ST_11);
            ST_11: up = (cur == ST_10);
            ST_10: up = (cur == ST_00);
            default: up = 1'b0;
        endcase
        return up;
    endfunction

    // The down sequence is the up sequence traversed backwards
    function automatic logic is_down_step(input logic [1:0] prev, input logic [1:0] cur);
        return is_up_step(cur, prev);
    endfunction

endpackage

// File: rtl/quad_updown_decoder_sync_ff.sv
// Multi-stage single-bit synchroniser for an asynchronous input.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sh;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh <= {sh[STAGES-2:0], d};
        end
    end

    assign q = sh[STAGES-1];

endmodule

// File: rtl/quad_updown_decoder.sv
// Quadrature A/B decoder with up/down position counter, parallel load and sticky error.
module quad_updown_decoder
    import quad_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    logic a_s;
    logic b_s;
    logic [1:0] cur;
    logic [1:0] prev_ab, prev_nxt;
    fsm_state_t state, state_nxt;
    logic [ARM_W-1:0] arm_cnt, arm_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic dir_nxt;
    logic step_nxt;
    logic err_nxt;
    logic up_t;
    logic down_t;
    logic bad_t;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a_in),
        .q     (a_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (b_in),
        .q     (b_s)
    );

    assign cur    = {a_s, b_s};
    assign up_t   = is_up_step(prev_ab, cur);
    assign down_t = is_down_step(prev_ab, cur);
    assign bad_t  = ((prev_ab ^ cur) == 2'b11);

    // State, history and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARMING;
            arm_cnt <= '0;
            prev_ab <= ST_00;
            count   <= '0;
            dir     <= DIR_DOWN;
            step    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_nxt;
            prev_ab <= prev_nxt;
            count   <= count_nxt;
            dir     <= dir_nxt;
            step    <= step_nxt;
            err     <= err_nxt;
        end
    end

    // Next-state decode: arming, transition classification, count/load and error flag.
    // ARMING keeps re-sampling the synchroniser output until the reset-cleared chain has
    // filled with the real pin levels, so a non-zero start position is never seen as a jump.
    always_comb begin
        state_nxt = state;
        arm_nxt   = arm_cnt;
        prev_nxt  = cur;
        count_nxt = count;
        dir_nxt   = dir;
        step_nxt  = 1'b0;
        err_nxt   = err;

        if (err_clr) begin
            err_nxt = 1'b0;
        end

        case (state)
            ARMING: begin
                if (arm_cnt == ARM_LAST) begin
                    state_nxt = TRACK;
                end else begin
                    arm_nxt = arm_cnt + ARM_W'(1);
                end
            end
            TRACK: begin
                if (bad_t) begin
                    err_nxt = 1'b1;
                end else if (!load && up_t) begin
                    count_nxt = count + WIDTH'(1);
                    dir_nxt   = DIR_UP;
                    step_nxt  = 1'b1;
                end else if (!load && down_t) begin
                    count_nxt = count - WIDTH'(1);
                    dir_nxt   = DIR_DOWN;
                    step_nxt  = 1'b1;
                end
            end
            default: state_nxt = ARMING;
        endcase

        if (load) begin
            count_nxt = din;
        end
    end

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed self-checking bench for quad_updown_decoder.
`timescale 1ns/1ps
module tb_quad_updown_decoder;

    logic       clk;
    logic       rst_n;
    logic       a_in;
    logic       b_in;
    logic       load;
    logic [3:0] din;
    logic       err_clr;
    logic [3:0] count;
    logic       dir;
    logic       step;
    logic       err;

    int checks = 0;
    int errors = 0;

    quad_updown_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .load    (load),
        .din     (din),
        .err_clr (err_clr),
        .count   (count),
        .dir     (dir),
        .step    (step),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a new AB level just after an edge and check the 3-edge latency and pulse width
    task automatic move(input string tag, input logic [1:0] ab, input logic [3:0] exp_cnt,
                        input logic exp_dir, input logic exp_step, input logic exp_err);
        a_in = ab[1];
        b_in = ab[0];
        repeat (2) @(posedge clk);
        #1 check({tag, ".early"}, {31'd0, step}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".step"}, {31'd0, step}, {31'd0, exp_step});
        check({tag, ".count"}, {28'd0, count}, {28'd0, exp_cnt});
        check({tag, ".dir"}, {31'd0, dir}, {31'd0, exp_dir});
        check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge clk);
        #1 check({tag, ".stepoff"}, {31'd0, step}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [3:0] v);
        load = 1'b1;
        din  = v;
        @(posedge clk);
        #1 load = 1'b0;
        check(tag, {28'd0, count}, {28'd0, v});
    endtask

    initial begin
        rst_n   = 1'b0;
        a_in    = 1'b1;
        b_in    = 1'b1;
        load    = 1'b0;
        din     = '0;
        err_clr = 1'b0;
        #23 rst_n = 1'b1;

        // Start at AB=11: arming must absorb it silently
        repeat (5) @(posedge clk);
        #1;
        check("arm.count", {28'd0, count}, 32'd0);
        check("arm.step", {31'd0, step}, 32'd0);
        check("arm.err", {31'd0, err}, 32'd0);
        check("arm.dir", {31'd0, dir}, 32'd0);

        // Walk to 00 along the up sequence
        move("pre1", 2'b10, 4'd1, 1'b1, 1'b1, 1'b0);
        move("pre2", 2'b00, 4'd2, 1'b1, 1'b1, 1'b0);

        // Load 8 then four up steps
        do_load("load8", 4'd8);
        move("up1", 2'b01, 4'd9,  1'b1, 1'b1, 1'b0);
        move("up2", 2'b11, 4'd10, 1'b1, 1'b1, 1'b0);
        move("up3", 2'b10, 4'd11, 1'b1, 1'b1, 1'b0);
        move("up4", 2'b00, 4'd12, 1'b1, 1'b1, 1'b0);

        // Load 1 then down steps through the zero wrap
        do_load("load1", 4'd1);
        move("dn1", 2'b10, 4'd0,  1'b0, 1'b1, 1'b0);
        move("dn2", 2'b11, 4'd15, 1'b0, 1'b1, 1'b0);
        move("dn3", 2'b01, 4'd14, 1'b0, 1'b1, 1'b0);
        move("dn4", 2'b00, 4'd13, 1'b0, 1'b1, 1'b0);

        // Illegal 00->11, then a legal step with err still set, then clear
        move("bad", 2'b11, 4'd13, 1'b0, 1'b0, 1'b1);
        move("afterbad", 2'b10, 4'd14, 1'b1, 1'b1, 1'b1);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("errclr", {31'd0, err}, 32'd0);
        move("upwrap", 2'b00, 4'd15, 1'b1, 1'b1, 1'b0);
        move("upwrap0", 2'b01, 4'd0, 1'b1, 1'b1, 1'b0);
        move("upto11", 2'b11, 4'd1, 1'b1, 1'b1, 1'b0);
        move("down10", 2'b01, 4'd0, 1'b0, 1'b1, 1'b0);

        // Down step 01->00 decoded in the same cycle as load of 5
        a_in = 1'b0;
        b_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b1;
        din  = 4'd5;
        @(posedge clk);
        #1 load = 1'b0;
        check("coll.count", {28'd0, count}, 32'd5);
        check("coll.step", {31'd0, step}, 32'd0);
        check("coll.dir", {31'd0, dir}, 32'd0);
        @(posedge clk);
        #1 check("coll.noreplay", {28'd0, count}, 32'd5);
        move("coll.next", 2'b01, 4'd6, 1'b1, 1'b1, 1'b0);

        // Set up count=12, err=1 and reset asynchronously mid-cycle
        do_load("load12", 4'd12);
        move("bad2", 2'b10, 4'd12, 1'b1, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("rst.count", {28'd0, count}, 32'd0);
        check("rst.err", {31'd0, err}, 32'd0);
        check("rst.dir", {31'd0, dir}, 32'd0);
        check("rst.step", {31'd0, step}, 32'd0);
        a_in = 1'b0;
        b_in = 1'b0;
        #10 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("rearm.count", {28'd0, count}, 32'd0);
        move("rearm.up", 2'b01, 4'd1, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
